// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the 3x3 convolver front end.
package conv_pkg;

   localparam int BIT_LEN = 8;
   localparam int M_LEN   = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_KERNEL = 2'd1,
      ST_PRIME  = 2'd2,
      ST_STREAM = 2'd3
   } state_e;

   localparam logic MODE_KERNEL = 1'b0;
   localparam logic MODE_IMAGE  = 1'b1;

endpackage

// File: rtl/line_buffer_2row.sv
// Two row buffers on one shared address; synchronous read-first, outputs one cycle after address.
module line_buffer_2row #(
   parameter int BIT_LEN   = 8,
   parameter int IMG_W_MAX = 640,
   parameter int ADDR_LEN  = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_LEN-1:0] i_addr,
   input  logic                i_re,
   input  logic                i_we,
   input  logic                i_wsel,
   input  logic [BIT_LEN-1:0]  i_wdata,
   output logic [BIT_LEN-1:0]  o_lb0,
   output logic [BIT_LEN-1:0]  o_lb1
);
   import conv_pkg::*;

   logic [BIT_LEN-1:0] mem0 [IMG_W_MAX];
   logic [BIT_LEN-1:0] mem1 [IMG_W_MAX];
   logic [BIT_LEN-1:0] lb0_q, lb0_d, lb1_q, lb1_d;

   // Read data sampled from the pre-write array contents, so same-address writes are read-first.
   always_comb begin
      lb0_d = lb0_q;
      lb1_d = lb1_q;
      if (i_re) begin
         lb0_d = mem0[i_addr];
         lb1_d = mem1[i_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (i_we && !i_wsel) mem0[i_addr] <= i_wdata;
      if (i_we &&  i_wsel) mem1[i_addr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lb0_q <= '0;
         lb1_q <= '0;
      end else begin
         lb0_q <= lb0_d;
         lb1_q <= lb1_d;
      end
   end

   assign o_lb0 = lb0_q;
   assign o_lb1 = lb1_q;

endmodule

// File: rtl/conv_feeder.sv
// Raster byte stream -> 3-row columns for the 3x3 convolver.
// Kernel packing (mode 0) exists only when CONV_FEED_KERNEL_EN is defined.
module conv_feeder #(
   parameter int BIT_LEN   = conv_pkg::BIT_LEN,
   parameter int IMG_W_MAX = 640,
   parameter int ADDR_LEN  = 10
) (
   input  logic                CLK100MHZ,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_mode,
   input  logic [ADDR_LEN-1:0] i_width,
   input  logic [ADDR_LEN-1:0] i_height,
   input  logic [BIT_LEN-1:0]  i_pixel,
   input  logic                i_pixel_valid,
   output logic                o_pixel_ready,
   output logic [BIT_LEN-1:0]  o_dato0,
   output logic [BIT_LEN-1:0]  o_dato1,
   output logic [BIT_LEN-1:0]  o_dato2,
   output logic                o_selecK_I,
   output logic                o_valid,
   output logic                o_win_valid,
   output logic                o_busy,
   output logic                o_frame_done
);
   import conv_pkg::*;

   state_e              state_q, state_d;
   logic [ADDR_LEN-1:0] width_q, width_d, height_q, height_d;
   logic [ADDR_LEN-1:0] col_q, col_d, row_q, row_d;
   // Rows rotate between the two banks instead of being copied: swap marks the oldest-row bank.
   logic                swap_q, swap_d, rd_swap_q, rd_swap_d;
   logic [BIT_LEN-1:0]  dato2_q, dato2_d;
   logic                valid_q, valid_d, win_q, win_d, done_q, done_d;
   logic                accept, last_col, last_row, start_ok, go_kernel, go_image;
   logic                lb_re, lb_we, lb_wsel;
   logic [BIT_LEN-1:0]  lb0, lb1, lb_old, lb_mid;
`ifdef CONV_FEED_KERNEL_EN
   logic [BIT_LEN-1:0]  kb0_q, kb0_d, kb1_q, kb1_d, kc0_q, kc0_d, kc1_q, kc1_d;
   logic                selk_q, selk_d, img_src_q, img_src_d;
`endif

   assign accept   = i_pixel_valid && (state_q != ST_IDLE);
   assign last_col = (col_q == width_q - ADDR_LEN'(1));
   assign last_row = (row_q == height_q - ADDR_LEN'(1));
   assign start_ok = (i_width >= ADDR_LEN'(3)) && (i_height >= ADDR_LEN'(3)) &&
                     (int'(i_width) <= IMG_W_MAX);
`ifdef CONV_FEED_KERNEL_EN
   assign go_kernel = (i_mode == MODE_KERNEL);
   assign go_image  = (i_mode == MODE_IMAGE) && start_ok;
`else
   logic unused_mode;
   assign unused_mode = i_mode;
   assign go_kernel   = 1'b0;
   assign go_image    = start_ok;
`endif

   always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      height_d  = height_q;
      col_d     = col_q;
      row_d     = row_q;
      swap_d    = swap_q;
      rd_swap_d = rd_swap_q;
      dato2_d   = dato2_q;
      valid_d   = 1'b0;
      win_d     = 1'b0;
      done_d    = 1'b0;
      lb_re     = 1'b0;
      lb_we     = 1'b0;
      lb_wsel   = swap_q;
`ifdef CONV_FEED_KERNEL_EN
      kb0_d     = kb0_q;
      kb1_d     = kb1_q;
      kc0_d     = kc0_q;
      kc1_d     = kc1_q;
      selk_d    = selk_q;
      img_src_d = img_src_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (i_start && (go_kernel || go_image)) begin
               width_d  = i_width;
               height_d = i_height;
               col_d    = '0;
               row_d    = '0;
               swap_d   = 1'b0;
               state_d  = go_kernel ? ST_KERNEL : ST_PRIME;
            end
         end
`ifdef CONV_FEED_KERNEL_EN
         // col counts the byte within a kernel column, row counts kernel columns.
         ST_KERNEL: begin
            if (accept) begin
               if (col_q == ADDR_LEN'(0)) kb0_d = i_pixel;
               if (col_q == ADDR_LEN'(1)) kb1_d = i_pixel;
               col_d = col_q + ADDR_LEN'(1);
               if (col_q == ADDR_LEN'(M_LEN-1)) begin
                  kc0_d     = kb0_q;
                  kc1_d     = kb1_q;
                  dato2_d   = i_pixel;
                  valid_d   = 1'b1;
                  selk_d    = 1'b0;
                  img_src_d = 1'b0;
                  col_d     = '0;
                  row_d     = row_q + ADDR_LEN'(1);
                  if (row_q == ADDR_LEN'(M_LEN-1)) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
         end
`endif
         ST_PRIME: begin
            if (accept) begin
               lb_we   = 1'b1;
               lb_wsel = row_q[0];
               col_d   = col_q + ADDR_LEN'(1);
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + ADDR_LEN'(1);
                  if (row_q[0]) state_d = ST_STREAM;
               end
            end
         end
         ST_STREAM: begin
            if (accept) begin
               lb_re     = 1'b1;
               lb_we     = 1'b1;
               lb_wsel   = swap_q;
               rd_swap_d = swap_q;
               dato2_d   = i_pixel;
               valid_d   = 1'b1;
               win_d     = (col_q >= ADDR_LEN'(2));
`ifdef CONV_FEED_KERNEL_EN
               selk_d    = 1'b1;
               img_src_d = 1'b1;
`endif
               col_d     = col_q + ADDR_LEN'(1);
               if (last_col) begin
                  col_d  = '0;
                  row_d  = row_q + ADDR_LEN'(1);
                  swap_d = ~swap_q;
                  if (last_row) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ST_IDLE;
         width_q   <= '0;
         height_q  <= '0;
         col_q     <= '0;
         row_q     <= '0;
         swap_q    <= 1'b0;
         rd_swap_q <= 1'b0;
         dato2_q   <= '0;
         valid_q   <= 1'b0;
         win_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef CONV_FEED_KERNEL_EN
         kb0_q     <= '0;
         kb1_q     <= '0;
         kc0_q     <= '0;
         kc1_q     <= '0;
         selk_q    <= 1'b0;
         img_src_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         width_q   <= width_d;
         height_q  <= height_d;
         col_q     <= col_d;
         row_q     <= row_d;
         swap_q    <= swap_d;
         rd_swap_q <= rd_swap_d;
         dato2_q   <= dato2_d;
         valid_q   <= valid_d;
         win_q     <= win_d;
         done_q    <= done_d;
`ifdef CONV_FEED_KERNEL_EN
         kb0_q     <= kb0_d;
         kb1_q     <= kb1_d;
         kc0_q     <= kc0_d;
         kc1_q     <= kc1_d;
         selk_q    <= selk_d;
         img_src_q <= img_src_d;
`endif
      end
   end

   line_buffer_2row #(
      .BIT_LEN  (BIT_LEN),
      .IMG_W_MAX(IMG_W_MAX),
      .ADDR_LEN (ADDR_LEN)
   ) u_lb (
      .clk    (CLK100MHZ),
      .rst_n  (i_reset),
      .i_addr (col_q),
      .i_re   (lb_re),
      .i_we   (lb_we),
      .i_wsel (lb_wsel),
      .i_wdata(i_pixel),
      .o_lb0  (lb0),
      .o_lb1  (lb1)
   );

   assign lb_old = rd_swap_q ? lb1 : lb0;
   assign lb_mid = rd_swap_q ? lb0 : lb1;

`ifdef CONV_FEED_KERNEL_EN
   assign o_dato0    = img_src_q ? lb_old : kc0_q;
   assign o_dato1    = img_src_q ? lb_mid : kc1_q;
   assign o_selecK_I = selk_q;
`else
   assign o_dato0    = lb_old;
   assign o_dato1    = lb_mid;
   assign o_selecK_I = 1'b1;
`endif
   assign o_dato2       = dato2_q;
   assign o_valid       = valid_q;
   assign o_win_valid   = win_q;
   assign o_frame_done  = done_q;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_pixel_ready = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_feeder.sv
// Directed self-checking bench for conv_feeder (kernel test only when CONV_FEED_KERNEL_EN is defined).
module tb_conv_feeder;

   logic       CLK100MHZ = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_start = 1'b0;
   logic       i_mode = 1'b1;
   logic [9:0] i_width = '0;
   logic [9:0] i_height = '0;
   logic [7:0] i_pixel = '0;
   logic       i_pixel_valid = 1'b0;
   logic       o_pixel_ready, o_selecK_I, o_valid, o_win_valid, o_busy, o_frame_done;
   logic [7:0] o_dato0, o_dato1, o_dato2;

   conv_feeder #(.BIT_LEN(8), .IMG_W_MAX(640), .ADDR_LEN(10)) dut (
      .CLK100MHZ    (CLK100MHZ),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_mode       (i_mode),
      .i_width      (i_width),
      .i_height     (i_height),
      .i_pixel      (i_pixel),
      .i_pixel_valid(i_pixel_valid),
      .o_pixel_ready(o_pixel_ready),
      .o_dato0      (o_dato0),
      .o_dato1      (o_dato1),
      .o_dato2      (o_dato2),
      .o_selecK_I   (o_selecK_I),
      .o_valid      (o_valid),
      .o_win_valid  (o_win_valid),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   typedef struct packed {
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] d2;
      logic       win;
      logic       done;
      logic       selk;
   } col_t;

`ifdef CONV_FEED_KERNEL_EN
   localparam logic SELK_RST = 1'b0;
`else
   localparam logic SELK_RST = 1'b1;
`endif

   col_t cap[$];
   int   checks = 0;
   int   errors = 0;
   int   lat_err = 0;
   logic acc_prev = 1'b0;

   // Capture columns; a valid must follow an accepted byte, and done only comes with valid.
   always @(negedge CLK100MHZ) begin
      if (o_valid === 1'b1 && !acc_prev) lat_err++;
      if (o_frame_done === 1'b1 && o_valid !== 1'b1) lat_err++;
      if (o_valid === 1'b1)
         cap.push_back(col_t'{o_dato0, o_dato1, o_dato2, o_win_valid, o_frame_done, o_selecK_I});
      acc_prev = i_pixel_valid && o_pixel_ready && i_reset;
   end

   task automatic tick();
      @(posedge CLK100MHZ);
      #1;
   endtask

   task automatic start_frame(input logic mode, input int w, input int h);
      i_mode = mode;
      i_width = 10'(w);
      i_height = 10'(h);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] p);
      i_pixel = p;
      i_pixel_valid = 1'b1;
      tick();
      i_pixel_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] base, input int w, input int h, input bit gaps);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            if (gaps && ((r * w + c) % 3 == 1)) tick();
            if (gaps && c == 0) begin tick(); tick(); end
            send(base + 8'(r * 16 + c));
         end
   endtask

   function automatic col_t exp_col(input logic [7:0] base, input int i, input int w, input int h);
      col_t e;
      int r, c;
      r = 2 + i / w;
      c = i % w;
      e.d0 = base + 8'((r - 2) * 16 + c);
      e.d1 = base + 8'((r - 1) * 16 + c);
      e.d2 = base + 8'(r * 16 + c);
      e.win = (c >= 2);
      e.done = (r == h - 1) && (c == w - 1);
      e.selk = 1'b1;
      return e;
   endfunction

   task automatic test_reset();
      #1 i_reset = 1'b0;
      #1;
      checks++;
      if ({o_valid, o_win_valid, o_frame_done, o_busy, o_pixel_ready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 00000", {o_valid, o_win_valid, o_frame_done, o_busy, o_pixel_ready});
      end
      checks++;
      if ({o_dato0, o_dato1, o_dato2} !== 24'h0) begin
         errors++;
         $display("FAIL reset_data got %h want 000000", {o_dato0, o_dato1, o_dato2});
      end
      checks++;
      if (o_selecK_I !== SELK_RST) begin
         errors++;
         $display("FAIL reset_selk got %b want %b", o_selecK_I, SELK_RST);
      end
      tick(); tick();
      i_reset = 1'b1;
      tick();
   endtask

`ifdef CONV_FEED_KERNEL_EN
   task automatic test_kernel();
      cap.delete();
      lat_err = 0;
      start_frame(1'b0, 0, 0);
      for (int k = 1; k <= 9; k++) send(8'(k));
      tick(); tick();
      checks++;
      if (cap.size() != 3) begin
         errors++;
         $display("FAIL kernel_count got %0d want 3", cap.size());
      end
      if (cap.size() == 3) begin
         checks++;
         if (cap[0] !== col_t'{8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL kernel_col0 got %h want %h", cap[0], col_t'{8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0});
         end
         checks++;
         if (cap[1] !== col_t'{8'd4, 8'd5, 8'd6, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL kernel_col1 got %h want %h", cap[1], col_t'{8'd4, 8'd5, 8'd6, 1'b0, 1'b0, 1'b0});
         end
         checks++;
         if (cap[2] !== col_t'{8'd7, 8'd8, 8'd9, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL kernel_col2 got %h want %h", cap[2], col_t'{8'd7, 8'd8, 8'd9, 1'b0, 1'b1, 1'b0});
         end
      end
      checks++;
      if (o_busy !== 1'b0 || lat_err != 0) begin
         errors++;
         $display("FAIL kernel_end busy=%b lat_err=%0d want 0/0", o_busy, lat_err);
      end
   endtask
`else
   task automatic test_mode_ignored();
      cap.delete();
      start_frame(1'b0, 4, 3);
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL mode0_busy got %b want 1", o_busy);
      end
      send_frame(8'h00, 4, 3, 1'b0);
      tick(); tick();
      checks++;
      if (cap.size() != 4) begin
         errors++;
         $display("FAIL mode0_count got %0d want 4", cap.size());
      end
      else if (cap[0] !== col_t'{8'h00, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL mode0_col0 got %h want %h", cap[0], col_t'{8'h00, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1});
      end
   endtask
`endif

   task automatic test_image();
      cap.delete();
      lat_err = 0;
      start_frame(1'b1, 4, 3);
      checks++;
      if (o_busy !== 1'b1 || o_pixel_ready !== 1'b1) begin
         errors++;
         $display("FAIL image_busy got %b%b want 11", o_busy, o_pixel_ready);
      end
      send_frame(8'h00, 4, 3, 1'b0);
      tick(); tick();
      checks++;
      if (cap.size() != 4) begin
         errors++;
         $display("FAIL image_count got %0d want 4", cap.size());
      end
      if (cap.size() == 4) begin
         checks++;
         if (cap[0] !== col_t'{8'h00, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL image_col0 got %h want %h", cap[0], col_t'{8'h00, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1});
         end
         checks++;
         if (cap[1] !== col_t'{8'h01, 8'h11, 8'h21, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL image_col1 got %h want %h", cap[1], col_t'{8'h01, 8'h11, 8'h21, 1'b0, 1'b0, 1'b1});
         end
         checks++;
         if (cap[2] !== col_t'{8'h02, 8'h12, 8'h22, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL image_col2 got %h want %h", cap[2], col_t'{8'h02, 8'h12, 8'h22, 1'b1, 1'b0, 1'b1});
         end
         checks++;
         if (cap[3] !== col_t'{8'h03, 8'h13, 8'h23, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL image_col3 got %h want %h", cap[3], col_t'{8'h03, 8'h13, 8'h23, 1'b1, 1'b1, 1'b1});
         end
      end
      checks++;
      if (o_busy !== 1'b0 || o_pixel_ready !== 1'b0 || lat_err != 0) begin
         errors++;
         $display("FAIL image_end busy=%b ready=%b lat_err=%0d want 0/0/0", o_busy, o_pixel_ready, lat_err);
      end
   endtask

   task automatic test_stalls();
      cap.delete();
      lat_err = 0;
      start_frame(1'b1, 4, 3);
      send_frame(8'h00, 4, 3, 1'b1);
      tick(); tick();
      checks++;
      if (cap.size() != 4) begin
         errors++;
         $display("FAIL stall_count got %0d want 4", cap.size());
      end
      for (int i = 0; i < cap.size(); i++) begin
         checks++;
         if (cap[i] !== exp_col(8'h00, i, 4, 3)) begin
            errors++;
            $display("FAIL stall_col%0d got %h want %h", i, cap[i], exp_col(8'h00, i, 4, 3));
         end
      end
      checks++;
      if (lat_err != 0) begin
         errors++;
         $display("FAIL stall_gap_valid got %0d want 0", lat_err);
      end
   endtask

   task automatic test_illegal();
      start_frame(1'b1, 2, 3);
      checks++;
      if (o_busy !== 1'b0 || o_pixel_ready !== 1'b0) begin
         errors++;
         $display("FAIL illegal_w2 got %b%b want 00", o_busy, o_pixel_ready);
      end
      start_frame(1'b1, 700, 3);
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL illegal_w700 got %b want 0", o_busy);
      end
      start_frame(1'b1, 4, 2);
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL illegal_h2 got %b want 0", o_busy);
      end
      cap.delete();
      lat_err = 0;
      start_frame(1'b1, 4, 3);
      for (int c = 0; c < 3; c++) send(8'(c));
      i_start = 1'b1;
      i_width = 10'd5;
      i_height = 10'd5;
      send(8'h03);
      i_start = 1'b0;
      for (int r = 1; r < 3; r++)
         for (int c = 0; c < 4; c++) send(8'(r * 16 + c));
      tick(); tick();
      checks++;
      if (cap.size() != 4) begin
         errors++;
         $display("FAIL busy_start_count got %0d want 4", cap.size());
      end
      for (int i = 0; i < cap.size(); i++) begin
         checks++;
         if (cap[i] !== exp_col(8'h00, i, 4, 3)) begin
            errors++;
            $display("FAIL busy_start_col%0d got %h want %h", i, cap[i], exp_col(8'h00, i, 4, 3));
         end
      end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_end got %b want 0", o_busy);
      end
   endtask

   task automatic test_reset_mid_stream();
      int wins;
      start_frame(1'b1, 5, 4);
      for (int k = 0; k < 12; k++) send(8'h80 + 8'((k / 5) * 16 + (k % 5)));
      i_pixel = 8'hEE;
      i_pixel_valid = 1'b1;
      #2 i_reset = 1'b0;
      #1;
      checks++;
      if ({o_valid, o_win_valid, o_frame_done, o_busy, o_pixel_ready} !== 5'b0) begin
         errors++;
         $display("FAIL midreset_ctrl got %b want 00000", {o_valid, o_win_valid, o_frame_done, o_busy, o_pixel_ready});
      end
      checks++;
      if ({o_dato0, o_dato1, o_dato2} !== 24'h0) begin
         errors++;
         $display("FAIL midreset_data got %h want 000000", {o_dato0, o_dato1, o_dato2});
      end
      i_pixel_valid = 1'b0;
      tick();
      i_reset = 1'b1;
      tick();
      cap.delete();
      lat_err = 0;
      start_frame(1'b1, 5, 4);
      send_frame(8'h40, 5, 4, 1'b0);
      tick(); tick();
      checks++;
      if (cap.size() != 10) begin
         errors++;
         $display("FAIL newframe_count got %0d want 10", cap.size());
      end
      wins = 0;
      for (int i = 0; i < cap.size(); i++) begin
         if (cap[i].win === 1'b1) wins++;
         checks++;
         if (cap[i] !== exp_col(8'h40, i, 5, 4)) begin
            errors++;
            $display("FAIL newframe_col%0d got %h want %h", i, cap[i], exp_col(8'h40, i, 5, 4));
         end
      end
      checks++;
      if (wins != 6 || lat_err != 0) begin
         errors++;
         $display("FAIL newframe_win got %0d lat_err=%0d want 6/0", wins, lat_err);
      end
   endtask

   initial begin
      test_reset();
`ifdef CONV_FEED_KERNEL_EN
      test_kernel();
`else
      test_mode_ignored();
`endif
      test_image();
      test_stalls();
      test_illegal();
      test_reset_mid_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
